// File: rtl/duty_step_ctrl_pkg.sv
// Shared types, default parameters and a counter-width helper for the
// duty_step_ctrl block (button-driven saturating duty level).
package duty_step_pkg;

   localparam int unsigned TICK_DIV_DEF     = 2;
   localparam int unsigned DEB_SAMPLES_DEF  = 3;
   localparam int unsigned REPEAT_DELAY_DEF = 8;
   localparam int unsigned REPEAT_RATE_DEF  = 2;
   localparam int unsigned DUTY_MAX_DEF     = 10;
   localparam int unsigned DUTY_INIT_DEF    = 5;
   localparam int unsigned DUTY_W_DEF       = 4;

   // Per-button stepping state.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } step_state_t;

   // Bits needed for a counter that must hold values 0..max_val (at least 1).
   function automatic int unsigned cnt_width(input int unsigned max_val);
      int unsigned w;
      w = $clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/duty_step_ctrl_if.sv
// Control/status bundle of duty_step_ctrl: enable and raw buttons in,
// duty level and flags out. master = driver side, slave = the block.
interface duty_step_ctrl_if
   import duty_step_pkg::*;
#(
   parameter int unsigned DUTY_W = DUTY_W_DEF
);
   logic              ena;
   logic              btn_inc;
   logic              btn_dec;
   logic [DUTY_W-1:0] duty;
   logic              duty_upd;
   logic              at_max;
   logic              at_min;

   modport master (
      output ena, btn_inc, btn_dec,
      input  duty, duty_upd, at_max, at_min
   );

   modport slave (
      input  ena, btn_inc, btn_dec,
      output duty, duty_upd, at_max, at_min
   );
endinterface

// File: rtl/duty_step_ctrl_debounce.sv
// Two-flop synchroniser plus tick-sampled debouncer for one raw button.
// rise_o/fall_o are combinational and flag the tick on which the stable
// level is about to change, so the parent can act on that same edge.
module btn_debounce
   import duty_step_pkg::*;
#(
   parameter int unsigned DEB_SAMPLES = DEB_SAMPLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic tick_i,
   input  logic btn_i,
   output logic stable_o,
   output logic rise_o,
   output logic fall_o
);
   localparam int unsigned   CW       = cnt_width(DEB_SAMPLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_SAMPLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          stable_q;
   logic          stable_d;

   // Bring the asynchronous button into the clock domain; runs regardless of enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
      end
   end

   // Count consecutive disagreeing ticks; adopt the new level after DEB_SAMPLES of them.
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (tick_i) begin
         if (sync2_q != stable_q) begin
            if (cnt_q >= CNT_LAST) begin
               stable_d = sync2_q;
               cnt_d    = {CW{1'b0}};
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end else begin
            cnt_d = {CW{1'b0}};
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Debounce state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= {CW{1'b0}};
         stable_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable_o = stable_q;
   assign rise_o   = ~stable_q &  stable_d;
   assign fall_o   =  stable_q & ~stable_d;

endmodule

// File: rtl/duty_step_ctrl.sv
// Converts debounced increase/decrease buttons into a saturating duty level
// with hold-to-repeat stepping. Index 0 is the increase button, 1 decrease.
module duty_step_ctrl
   import duty_step_pkg::*;
#(
   parameter int unsigned TICK_DIV     = TICK_DIV_DEF,
   parameter int unsigned DEB_SAMPLES  = DEB_SAMPLES_DEF,
   parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_DEF,
   parameter int unsigned REPEAT_RATE  = REPEAT_RATE_DEF,
   parameter int unsigned DUTY_MAX     = DUTY_MAX_DEF,
   parameter int unsigned DUTY_INIT    = DUTY_INIT_DEF,
   parameter int unsigned DUTY_W       = DUTY_W_DEF
) (
   input logic             clk,
   input logic             rst,
   duty_step_ctrl_if.slave bus
);
   localparam int unsigned       TW        = cnt_width(TICK_DIV - 1);
   localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
   localparam int unsigned       HMAX      = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned       HW        = cnt_width(HMAX);
   localparam logic [HW-1:0]     DELAY_LD  = HW'(REPEAT_DELAY);
   localparam logic [HW-1:0]     RATE_LD   = HW'(REPEAT_RATE);
   localparam logic [DUTY_W-1:0] DMAX_V    = DUTY_W'(DUTY_MAX);
   localparam logic [DUTY_W-1:0] DINIT_V   = DUTY_W'(DUTY_INIT);
   localparam logic [DUTY_W-1:0] DZERO_V   = {DUTY_W{1'b0}};

   logic [TW-1:0]     tick_cnt_q;
   logic [TW-1:0]     tick_cnt_d;
   logic              tick_s;
   logic [1:0]        raw_s;
   logic [1:0]        stable_s;
   logic [1:0]        rise_s;
   logic [1:0]        fall_s;
   logic [1:0]        lvl_s;
   logic              both_s;
   logic [1:0]        step_s;
   step_state_t       st_q    [2];
   step_state_t       st_d    [2];
   logic [HW-1:0]     hcnt_q  [2];
   logic [HW-1:0]     hcnt_d  [2];
   logic [DUTY_W-1:0] duty_q;
   logic [DUTY_W-1:0] duty_d;
   logic              upd_q;
   logic              at_max_q;
   logic              at_min_q;

   assign tick_s = bus.ena & (tick_cnt_q == TICK_LAST);
   assign raw_s  = {bus.btn_dec, bus.btn_inc};

   // Sample-tick divider; frozen while the block is disabled.
   always_comb begin
      if (!bus.ena) begin
         tick_cnt_d = tick_cnt_q;
      end else if (tick_s) begin
         tick_cnt_d = {TW{1'b0}};
      end else begin
         tick_cnt_d = tick_cnt_q + TW'(1);
      end
   end

   // Tick divider register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt_q <= {TW{1'b0}};
      end else begin
         tick_cnt_q <= tick_cnt_d;
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_btn
      btn_debounce #(
         .DEB_SAMPLES(DEB_SAMPLES)
      ) u_deb (
         .clk     (clk),
         .rst     (rst),
         .tick_i  (tick_s),
         .btn_i   (raw_s[g]),
         .stable_o(stable_s[g]),
         .rise_o  (rise_s[g]),
         .fall_o  (fall_s[g])
      );
   end

   // Level each button will have after this edge; arbitration uses it so a
   // press landing while the other button is held is suppressed immediately.
   assign lvl_s  = (stable_s & ~fall_s) | rise_s;
   assign both_s = lvl_s[0] & lvl_s[1];

   // Per-button press/hold/repeat state machines, advanced on ticks only.
   always_comb begin
      step_s = 2'b00;
      for (int i = 0; i < 2; i++) begin
         st_d[i]   = st_q[i];
         hcnt_d[i] = hcnt_q[i];
      end
      if (tick_s) begin
         for (int i = 0; i < 2; i++) begin
            if (fall_s[i] || both_s) begin
               st_d[i]   = IDLE;
               hcnt_d[i] = {HW{1'b0}};
            end else begin
               case (st_q[i])
                  IDLE: begin
                     if (rise_s[i]) begin
                        st_d[i]   = HOLD;
                        hcnt_d[i] = DELAY_LD;
                        step_s[i] = 1'b1;
                     end else begin
                        st_d[i] = IDLE;
                     end
                  end
                  HOLD: begin
                     if (hcnt_q[i] <= HW'(1)) begin
                        st_d[i]   = REPEAT;
                        hcnt_d[i] = RATE_LD;
                        step_s[i] = 1'b1;
                     end else begin
                        hcnt_d[i] = hcnt_q[i] - HW'(1);
                     end
                  end
                  REPEAT: begin
                     if (hcnt_q[i] <= HW'(1)) begin
                        hcnt_d[i] = RATE_LD;
                        step_s[i] = 1'b1;
                     end else begin
                        hcnt_d[i] = hcnt_q[i] - HW'(1);
                     end
                  end
                  default: begin
                     st_d[i]   = IDLE;
                     hcnt_d[i] = {HW{1'b0}};
                  end
               endcase
            end
         end
      end else begin
         step_s = 2'b00;
      end
   end

   // FSM state and hold/repeat counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            st_q[i]   <= IDLE;
            hcnt_q[i] <= {HW{1'b0}};
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            st_q[i]   <= st_d[i];
            hcnt_q[i] <= hcnt_d[i];
         end
      end
   end

   // Saturating step of the duty level; arbitration guarantees at most one step.
   always_comb begin
      if (step_s[0] && (duty_q < DMAX_V)) begin
         duty_d = duty_q + DUTY_W'(1);
      end else if (step_s[1] && (duty_q > DZERO_V)) begin
         duty_d = duty_q - DUTY_W'(1);
      end else begin
         duty_d = duty_q;
      end
   end

   // Registered duty level, change pulse and limit flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_q   <= DINIT_V;
         upd_q    <= 1'b0;
         at_max_q <= (DINIT_V == DMAX_V);
         at_min_q <= (DINIT_V == DZERO_V);
      end else begin
         duty_q   <= duty_d;
         upd_q    <= (duty_d != duty_q);
         at_max_q <= (duty_d == DMAX_V);
         at_min_q <= (duty_d == DZERO_V);
      end
   end

   assign bus.duty     = duty_q;
   assign bus.duty_upd = upd_q;
   assign bus.at_max   = at_max_q;
   assign bus.at_min   = at_min_q;

endmodule

// File: tb/tb_duty_step_ctrl.sv
// Bench for duty_step_ctrl: directed button scenarios plus random stimulus,
// every cycle compared against a behavioural model of the button rules.
module tb_duty_step_ctrl;

   localparam int TD    = 2;
   localparam int DS    = 3;
   localparam int RD    = 8;
   localparam int RR    = 2;
   localparam int DMAX  = 10;
   localparam int DINIT = 5;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   duty_step_ctrl_if #(.DUTY_W(4)) bus ();

   duty_step_ctrl #(
      .TICK_DIV    (TD),
      .DEB_SAMPLES (DS),
      .REPEAT_DELAY(RD),
      .REPEAT_RATE (RR),
      .DUTY_MAX    (DMAX),
      .DUTY_INIT   (DINIT),
      .DUTY_W      (4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   int n_checks = 0;
   int n_errors = 0;
   int upd_seen = 0;

   // Behavioural model: sync pipeline, tick phase, debounce agreement counts,
   // and for each button whether it is "armed" plus ticks held since its press.
   int m_pipe0  [2];
   int m_pipe1  [2];
   int m_stable [2];
   int m_dis    [2];
   int m_active [2];
   int m_held   [2];
   int m_phase;
   int m_duty;
   int m_upd;

   task automatic check_value(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_pipe0[i]  = 0;
         m_pipe1[i]  = 0;
         m_stable[i] = 0;
         m_dis[i]    = 0;
         m_active[i] = 0;
         m_held[i]   = 0;
      end
      m_phase = 0;
      m_duty  = DINIT;
      m_upd   = 0;
   endfunction

   function automatic void model_clock();
      int raw  [2];
      int ns   [2];
      int rise [2];
      int fall [2];
      int step [2];
      int tick;
      int both;
      int nd;
      raw[0] = int'(bus.btn_inc);
      raw[1] = int'(bus.btn_dec);
      tick   = (bus.ena === 1'b1 && m_phase == TD - 1) ? 1 : 0;
      for (int i = 0; i < 2; i++) begin
         ns[i]   = m_stable[i];
         step[i] = 0;
         if (tick != 0) begin
            if (m_pipe1[i] != m_stable[i]) begin
               m_dis[i]++;
               if (m_dis[i] == DS) begin
                  ns[i]    = m_pipe1[i];
                  m_dis[i] = 0;
               end
            end else begin
               m_dis[i] = 0;
            end
         end
         rise[i]     = (ns[i] == 1 && m_stable[i] == 0) ? 1 : 0;
         fall[i]     = (ns[i] == 0 && m_stable[i] == 1) ? 1 : 0;
         m_stable[i] = ns[i];
      end
      both = (ns[0] == 1 && ns[1] == 1) ? 1 : 0;
      if (tick != 0) begin
         for (int i = 0; i < 2; i++) begin
            if (fall[i] != 0 || both != 0) begin
               m_active[i] = 0;
            end else if (rise[i] != 0) begin
               m_active[i] = 1;
               m_held[i]   = 0;
               step[i]     = 1;
            end else if (m_active[i] != 0) begin
               m_held[i]++;
               if (m_held[i] == RD || (m_held[i] > RD && (m_held[i] - RD) % RR == 0))
                  step[i] = 1;
            end
         end
      end
      nd = m_duty;
      if (step[0] != 0 && nd < DMAX) nd = nd + 1;
      else if (step[1] != 0 && nd > 0) nd = nd - 1;
      m_upd  = (nd != m_duty) ? 1 : 0;
      m_duty = nd;
      for (int i = 0; i < 2; i++) begin
         m_pipe1[i] = m_pipe0[i];
         m_pipe0[i] = raw[i];
      end
      if (bus.ena === 1'b1) m_phase = (m_phase + 1) % TD;
   endfunction

   task automatic compare_outputs();
      check_value("duty",     int'(bus.duty),     m_duty);
      check_value("duty_upd", int'(bus.duty_upd), m_upd);
      check_value("at_max",   int'(bus.at_max),   (m_duty == DMAX) ? 1 : 0);
      check_value("at_min",   int'(bus.at_min),   (m_duty == 0) ? 1 : 0);
      if (bus.duty_upd === 1'b1) upd_seen++;
   endtask

   // One clock: drive inputs (from negedge), advance model at posedge, compare at negedge.
   task automatic step_cycle(input bit en, input bit inc, input bit dec);
      bus.ena     = en;
      bus.btn_inc = inc;
      bus.btn_dec = dec;
      @(posedge clk);
      if (rst) model_reset();
      else     model_clock();
      @(negedge clk);
      compare_outputs();
   endtask

   task automatic run(input int n, input bit en, input bit inc, input bit dec);
      repeat (n) step_cycle(en, inc, dec);
   endtask

   // Assert reset asynchronously (mid-cycle), hold it n cycles, release at a negedge.
   task automatic do_reset(input int n);
      rst = 1'b1;
      #1;
      model_reset();
      compare_outputs();
      check_value("rst_duty_now", int'(bus.duty), DINIT);
      @(negedge clk);
      repeat (n) step_cycle(bus.ena, bus.btn_inc, bus.btn_dec);
      rst = 1'b0;
   endtask

   initial begin
      int len;
      int r;
      bit inc;
      bit dec;
      bit en;
      rst         = 1'b1;
      bus.ena     = 1'b1;
      bus.btn_inc = 1'b0;
      bus.btn_dec = 1'b0;
      model_reset();
      @(negedge clk);

      // Reset state and idle hold.
      do_reset(3);
      check_value("reset_duty",   int'(bus.duty),     5);
      check_value("reset_at_max", int'(bus.at_max),   0);
      check_value("reset_at_min", int'(bus.at_min),   0);
      check_value("reset_upd",    int'(bus.duty_upd), 0);
      run(100, 1'b1, 1'b0, 1'b0);
      check_value("idle_duty", int'(bus.duty), 5);

      // Clean short press: a single step, no repeat.
      upd_seen = 0;
      run(12, 1'b1, 1'b1, 1'b0);
      run(30, 1'b1, 1'b0, 1'b0);
      check_value("short_press_duty",  int'(bus.duty), 6);
      check_value("short_press_pulses", upd_seen, 1);

      // Bounce then stable high: one step only.
      do_reset(2);
      upd_seen = 0;
      for (int k = 0; k < 5; k++) step_cycle(1'b1, (k % 2) == 0, 1'b0);
      run(15, 1'b1, 1'b1, 1'b0);
      run(20, 1'b1, 1'b0, 1'b0);
      check_value("bounce_duty",   int'(bus.duty), 6);
      check_value("bounce_pulses", upd_seen, 1);

      // Long hold saturates at DUTY_MAX.
      do_reset(2);
      upd_seen = 0;
      run(80, 1'b1, 1'b1, 1'b0);
      check_value("hold_duty",   int'(bus.duty),   10);
      check_value("hold_at_max", int'(bus.at_max), 1);
      check_value("hold_pulses", upd_seen, 5);
      run(20, 1'b1, 1'b0, 1'b0);

      // Both pressed, release dec, re-press inc.
      do_reset(2);
      run(30, 1'b1, 1'b1, 1'b1);
      check_value("both_duty", int'(bus.duty), 5);
      run(30, 1'b1, 1'b1, 1'b0);
      check_value("after_release_duty", int'(bus.duty), 5);
      run(20, 1'b1, 1'b0, 1'b0);
      run(12, 1'b1, 1'b1, 1'b0);
      run(20, 1'b1, 1'b0, 1'b0);
      check_value("repress_duty", int'(bus.duty), 6);

      // Drive to 0, dec at floor, disabled press, reset during repeat.
      do_reset(2);
      run(80, 1'b1, 1'b0, 1'b1);
      run(20, 1'b1, 1'b0, 1'b0);
      check_value("floor_duty", int'(bus.duty), 0);
      upd_seen = 0;
      run(15, 1'b1, 1'b0, 1'b1);
      run(20, 1'b1, 1'b0, 1'b0);
      check_value("floor_stays",  int'(bus.duty),   0);
      check_value("floor_at_min", int'(bus.at_min), 1);
      check_value("floor_pulses", upd_seen, 0);
      run(30, 1'b0, 1'b1, 1'b0);
      check_value("disabled_duty", int'(bus.duty), 0);
      run(20, 1'b1, 1'b0, 1'b0);
      run(40, 1'b1, 1'b1, 1'b0);
      do_reset(2);
      check_value("rst_hold_duty", int'(bus.duty), 5);
      run(40, 1'b1, 1'b1, 1'b0);
      run(20, 1'b1, 1'b0, 1'b0);

      // Randomised segments: presses, bounce, enable drops and resets.
      for (int s = 0; s < 160; s++) begin
         len = $urandom_range(1, 40);
         r   = $urandom_range(0, 9);
         inc = (r < 4) || (r == 7);
         dec = (r >= 4 && r < 8);
         en  = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 4) == 0) begin
            for (int k = 0; k < len; k++)
               step_cycle(en, inc & ($urandom_range(0, 1) == 1), dec & ($urandom_range(0, 1) == 1));
         end else begin
            run(len, en, inc, dec);
         end
         if ($urandom_range(0, 29) == 0) do_reset($urandom_range(1, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
